// File: rtl/wb_decoder_n_if.sv
// Bus bundle between the core's Wishbone master port, the decoder, and the N slave ports.
// Address/data/we/sel fan out to the slaves outside this bundle; only routing signals live here.
interface wb_decoder_n_if #(
    parameter int unsigned NSLAVES = 2,
    parameter int unsigned AW      = 30,
    parameter int unsigned DW      = 32
);
    logic                  wb_cyc;
    logic                  wb_stb;
    logic [AW-1:0]         wb_addr;
    logic                  wb_stall;
    logic                  wb_ack;
    logic                  wb_err;
    logic [DW-1:0]         wb_miso;

    logic                  s_cyc;
    logic [NSLAVES-1:0]    s_stb;
    logic [NSLAVES-1:0]    s_stall;
    logic [NSLAVES-1:0]    s_ack;
    logic [NSLAVES-1:0]    s_err;
    logic [NSLAVES*DW-1:0] s_miso;

    // Upstream core: drives the request, sees the routed response.
    modport master (
        output wb_cyc, wb_stb, wb_addr,
        input  wb_stall, wb_ack, wb_err, wb_miso
    );

    // Decoder: slave to the core, fans requests out to the peripherals.
    modport slave (
        input  wb_cyc, wb_stb, wb_addr,
        output wb_stall, wb_ack, wb_err, wb_miso,
        output s_cyc, s_stb,
        input  s_stall, s_ack, s_err, s_miso
    );

    // Peripheral side, as seen by the SoC slaves.
    modport periph (
        input  s_cyc, s_stb,
        output s_stall, s_ack, s_err, s_miso
    );
endinterface

// File: rtl/wb_decoder_n.sv
// Single-master, N-slave pipelined Wishbone address decoder with in-order response routing,
// unmapped-address errors and a response timeout.
module wb_decoder_n #(
    parameter int unsigned           NSLAVES    = 2,
    parameter int unsigned           AW         = 30,
    parameter int unsigned           DW         = 32,
    parameter logic [NSLAVES*AW-1:0] SLAVE_BASE = '0,
    parameter logic [NSLAVES*AW-1:0] SLAVE_MASK = '0,
    parameter int unsigned           MAX_PEND   = 4,
    parameter int unsigned           TIMEOUT    = 255
) (
    input  logic         i_clk,
    input  logic         i_resetn,
    wb_decoder_n_if.slave bus
);

    localparam int unsigned PW = $clog2(MAX_PEND + 1);
    localparam int unsigned SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] pend, pend_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [SW-1:0] cur, cur_n;
    logic [SW-1:0] tgt;
    logic          mapped;

    logic          rsp_ack, rsp_err, rsp;
    logic          blk, stall, accept, acc_map, acc_unmap, tmo_fire;

    logic          ack_q, ack_n;
    logic          err_q, err_n;
    logic [DW-1:0] miso_q, miso_n;

    // Scanning from the top down lets the lowest matching slave index win.
    always_comb begin
        tgt    = '0;
        mapped = 1'b0;
        for (int unsigned i = NSLAVES; i > 0; i--) begin
            if ((bus.wb_addr & SLAVE_MASK[(i-1)*AW +: AW]) == SLAVE_BASE[(i-1)*AW +: AW]) begin
                tgt    = SW'(i - 1);
                mapped = 1'b1;
            end
        end
    end

    always_comb begin
        rsp_ack   = bus.s_ack[cur];
        rsp_err   = bus.s_err[cur];
        rsp       = (rsp_ack || rsp_err) && (pend != '0);
        // A full queue still admits a request when a response retires one in the same cycle.
        blk       = ((pend == PW'(MAX_PEND)) && !rsp)
                 || ((state == BUSY) && (tgt != cur))
                 || (!mapped && (pend != '0));
        stall     = bus.wb_stb && (blk || (mapped && bus.s_stall[tgt]));
        accept    = bus.wb_cyc && bus.wb_stb && !stall;
        acc_map   = accept && mapped;
        acc_unmap = accept && !mapped;
        tmo_fire  = bus.wb_cyc && (state == BUSY) && !accept && !rsp
                 && (tmo == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state  <= IDLE;
            pend   <= '0;
            tmo    <= '0;
            cur    <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            miso_q <= '0;
        end else begin
            state  <= state_n;
            pend   <= pend_n;
            tmo    <= tmo_n;
            cur    <= cur_n;
            ack_q  <= ack_n;
            err_q  <= err_n;
            miso_q <= miso_n;
        end
    end

    always_comb begin
        pend_n = pend;
        tmo_n  = tmo;
        cur_n  = cur;
        ack_n  = 1'b0;
        err_n  = 1'b0;
        miso_n = '0;

        if (!bus.wb_cyc) begin
            pend_n = '0;
            tmo_n  = '0;
        end else if (tmo_fire) begin
            pend_n = '0;
            tmo_n  = '0;
            err_n  = 1'b1;
        end else begin
            if (acc_map) begin
                cur_n = tgt;
            end
            if (acc_map && !rsp) begin
                pend_n = pend + PW'(1);
            end else if (rsp && !acc_map) begin
                pend_n = pend - PW'(1);
            end

            if (acc_map || rsp || (pend == '0)) begin
                tmo_n = '0;
            end else begin
                tmo_n = tmo + TW'(1);
            end

            if (rsp) begin
                ack_n = rsp_ack && !rsp_err;
                err_n = rsp_err;
                if (rsp_ack && !rsp_err) begin
                    miso_n = bus.s_miso[32'(cur)*DW +: DW];
                end
            end
            if (acc_unmap) begin
                err_n = 1'b1;
            end
        end

        state_n = (pend_n == '0) ? IDLE : BUSY;
    end

    always_comb begin
        bus.wb_stall = stall;
        bus.wb_ack   = ack_q;
        bus.wb_err   = err_q;
        bus.wb_miso  = miso_q;
        bus.s_cyc    = bus.wb_cyc;
        bus.s_stb    = '0;
        for (int unsigned i = 0; i < NSLAVES; i++) begin
            if (bus.wb_cyc && bus.wb_stb && !blk && mapped && (tgt == SW'(i))) begin
                bus.s_stb[i] = 1'b1;
            end
        end
    end

endmodule
